// File: rtl/fb_reader.sv
// Wishbone classic read master that streams the framebuffer in raster order
// into the write port of the pixel FIFO, pacing on the FIFO almost-full flag.
module fb_reader #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_start,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  output logic [31:0] wb_adr,
  input  logic        wb_ack,
  input  logic [31:0] wb_dat_sm,
  output logic [31:0] fifo_wdata,
  output logic        fifo_write,
  input  logic        fifo_walmost_full,
  output logic        frame_done,
  output logic        busy
);

  localparam int NWORDS = HDISP * VDISP;
  localparam int CW     = $clog2(NWORDS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          restart;

  // Strobe follows the state directly so it drops the instant reset asserts.
  assign wb_cyc = (state == READ);
  assign wb_stb = (state == READ);
  assign wb_we  = 1'b0;
  assign wb_sel = 4'b1111;
  assign wb_cti = 3'b000;
  assign wb_bte = 2'b00;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      wb_adr     <= BASE_ADR;
      restart    <= 1'b0;
      fifo_write <= 1'b0;
      fifo_wdata <= '0;
      frame_done <= 1'b0;
    end else begin
      fifo_write <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            count  <= '0;
            wb_adr <= BASE_ADR;
          end
          if (enable) state <= fifo_walmost_full ? HOLD : READ;
        end
        HOLD: begin
          if (frame_start) begin
            count  <= '0;
            wb_adr <= BASE_ADR;
          end
          if (!enable)                 state <= IDLE;
          else if (!fifo_walmost_full) state <= READ;
        end
        READ: begin
          if (wb_ack) begin
            if (restart || frame_start) begin
              // Resync: the completing word belongs to the old position, drop it.
              count   <= '0;
              wb_adr  <= BASE_ADR;
              restart <= 1'b0;
              state   <= IDLE;
            end else begin
              fifo_write <= 1'b1;
              fifo_wdata <= wb_dat_sm;
              if (count == LAST_CNT) begin
                count      <= '0;
                wb_adr     <= BASE_ADR;
                frame_done <= 1'b1;
              end else begin
                count  <= count + CW'(1);
                wb_adr <= wb_adr + 32'd4;
              end
              if (!enable)                state <= IDLE;
              else if (fifo_walmost_full) state <= HOLD;
            end
          end else if (frame_start) begin
            restart <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader: per-cycle vector table for a full frame plus
// hand-written sequences for stalls, almost-full, resync, enable drop and reset.
module tb_fb_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, frame_start;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_adr;
  logic        wb_ack;
  logic [31:0] wb_dat_sm;
  logic [31:0] fifo_wdata;
  logic        fifo_write, fifo_walmost_full, frame_done, busy;

  int checks   = 0;
  int failures = 0;

  fb_reader #(.HDISP(4), .VDISP(2), .BASE_ADR(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_adr(wb_adr), .wb_ack(wb_ack),
    .wb_dat_sm(wb_dat_sm), .fifo_wdata(fifo_wdata), .fifo_write(fifo_write),
    .fifo_walmost_full(fifo_walmost_full), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ack;
    logic [31:0] dat;
    logic        cyc;
    logic [31:0] adr;
    logic        fw;
    logic [31:0] wd;
    logic        fd;
    logic        bsy;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic fs, input logic ack,
                       input logic [31:0] dat, input logic af);
    enable = en; frame_start = fs; wb_ack = ack; wb_dat_sm = dat; fifo_walmost_full = af;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] dval(input int k);
    return 32'hCAFE_0000 + 32'(k);
  endfunction

  initial begin
    // Full frame with acks every cycle, then enable dropped on a wrapped word.
    vecs[0] = '{en:1, ack:0, dat:0, cyc:0, adr:32'h100, fw:0, wd:0, fd:0, bsy:0};
    for (int k = 1; k <= 8; k++)
      vecs[k] = '{en:1, ack:1, dat:dval(k-1), cyc:1, adr:32'h100 + 32'(4*(k-1)),
                  fw:(k >= 2), wd:(k >= 2) ? dval(k-2) : 32'h0, fd:0, bsy:1};
    vecs[9]  = '{en:1, ack:0, dat:0,       cyc:1, adr:32'h100, fw:1, wd:dval(7), fd:1, bsy:1};
    vecs[10] = '{en:0, ack:1, dat:dval(8), cyc:1, adr:32'h100, fw:0, wd:0,       fd:0, bsy:1};
    vecs[11] = '{en:0, ack:0, dat:0,       cyc:0, adr:32'h104, fw:1, wd:dval(8), fd:0, bsy:0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    chk("rst_stb", {31'b0, wb_stb}, 32'd0);
    chk("rst_adr", wb_adr, 32'h100);
    chk("rst_fw", {31'b0, fifo_write}, 32'd0);
    chk("rst_wdata", fifo_wdata, 32'd0);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("const_bus", {22'b0, wb_we, wb_sel, wb_cti, wb_bte}, {22'b0, 1'b0, 4'hF, 3'b000, 2'b00});
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, 1'b0, vecs[i].ack, vecs[i].dat, 1'b0);
      chk($sformatf("v%0d_cyc", i), {31'b0, wb_cyc}, {31'b0, vecs[i].cyc});
      chk($sformatf("v%0d_stb", i), {31'b0, wb_stb}, {31'b0, vecs[i].cyc});
      chk($sformatf("v%0d_adr", i), wb_adr, vecs[i].adr);
      chk($sformatf("v%0d_fw", i), {31'b0, fifo_write}, {31'b0, vecs[i].fw});
      if (vecs[i].fw) chk($sformatf("v%0d_wd", i), fifo_wdata, vecs[i].wd);
      chk($sformatf("v%0d_fd", i), {31'b0, frame_done}, {31'b0, vecs[i].fd});
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].bsy});
      tick();
    end

    // Slave stalls three cycles: address and strobe hold, one write per ack.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int w = 0; w < 3; w++) begin
      chk("stall_stb", {31'b0, wb_stb}, 32'd1);
      chk("stall_adr", wb_adr, 32'h100);
      chk("stall_fw", {31'b0, fifo_write}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_wr", {31'b0, fifo_write}, 32'd1);
    chk("stall_wd", fifo_wdata, 32'h1234_5678);
    chk("stall_adr2", wb_adr, 32'h104);
    tick();
    chk("stall_single", {31'b0, fifo_write}, 32'd0);
    chk("stall_stb2", {31'b0, wb_stb}, 32'd1);

    // Almost-full rises during word 2: it is written, then HOLD until release.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hA0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b1, 32'hA1, 1'b0); tick();
    chk("af_adr", wb_adr, 32'h108);
    drive(1'b1, 1'b0, 1'b1, 32'hA2, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("af_hold_cyc", {31'b0, wb_cyc}, 32'd0);
    chk("af_wr", {31'b0, fifo_write}, 32'd1);
    chk("af_wd", fifo_wdata, 32'hA2);
    chk("af_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("af_still_hold", {31'b0, wb_stb}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("af_resume_cyc", {31'b0, wb_cyc}, 32'd1);
    chk("af_resume_adr", wb_adr, 32'h10C);

    // frame_start while a read at 0x110 is pending; then coincident with ack.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hB0 + 32'(k), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("fs_adr", wb_adr, 32'h110);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    chk("fs_pending_stb", {31'b0, wb_stb}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("fs_nowr", {31'b0, fifo_write}, 32'd0);
    chk("fs_nofd", {31'b0, frame_done}, 32'd0);
    chk("fs_idle", {31'b0, busy}, 32'd0);
    chk("fs_adr_base", wb_adr, 32'h100);
    tick();
    chk("fs_restart_cyc", {31'b0, wb_cyc}, 32'd1);
    chk("fs_restart_adr", wb_adr, 32'h100);
    drive(1'b1, 1'b0, 1'b1, 32'hC0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 32'hBEEF, 1'b0);
    chk("fsack_adr", wb_adr, 32'h104);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("fsack_nowr", {31'b0, fifo_write}, 32'd0);
    chk("fsack_adr_base", wb_adr, 32'h100);
    chk("fsack_idle", {31'b0, busy}, 32'd0);

    // enable dropped while the read at 0x104 is outstanding.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hE0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("en_hold_stb", {31'b0, wb_stb}, 32'd1);
    chk("en_hold_adr", wb_adr, 32'h104);
    drive(1'b0, 1'b0, 1'b1, 32'hE1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("en_wr", {31'b0, fifo_write}, 32'd1);
    chk("en_wd", fifo_wdata, 32'hE1);
    chk("en_busy", {31'b0, busy}, 32'd0);
    chk("en_adr", wb_adr, 32'h108);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("en_resume_cyc", {31'b0, wb_cyc}, 32'd1);
    chk("en_resume_adr", wb_adr, 32'h108);

    // Asynchronous reset in the middle of a READ with a write in flight.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hF0, 1'b0); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'b0, wb_cyc}, 32'd0);
    chk("arst_stb", {31'b0, wb_stb}, 32'd0);
    chk("arst_adr", wb_adr, 32'h100);
    chk("arst_fw", {31'b0, fifo_write}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("arst_ack_ignored", wb_adr, 32'h100);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("arst_start_cyc", {31'b0, wb_cyc}, 32'd1);
    chk("arst_start_adr", wb_adr, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
